// File: rtl/serial_a_paralelo_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_a_paralelo_rx_if
// Description : Lane-side bundle for the serial-to-parallel receiver: serial
//               bit in, received byte, byte strobe and lock indication.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_a_paralelo_rx_if;
  logic       in;
  logic [7:0] out;
  logic       valid_out;
  logic       active;

  // Side that drives the serial line and consumes the bytes
  modport master (
    output in,
    input  out,
    input  valid_out,
    input  active
  );

  // Receiver side
  modport slave (
    input  in,
    output out,
    output valid_out,
    output active
  );
endinterface
`default_nettype wire

// File: rtl/serial_a_paralelo_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_a_paralelo_rx
// Description : Deserialises an MSB-first bit stream into bytes, aligns on
//               the COM symbol, declares lock after a run of aligned COMs and
//               strobes every non-COM byte out once locked.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_a_paralelo_rx #(
  parameter logic [7:0] COM        = 8'hBC,
  parameter int         COM_NEEDED = 4
) (
  input  wire                    clk32f,
  input  wire                    reset,
  serial_a_paralelo_rx_if.slave  bus
);

  localparam logic [3:0] c_com_needed = 4'(COM_NEEDED);

  typedef enum logic [1:0] {
    ST_UNALIGNED = 2'd0,
    ST_ALIGNING  = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_t;

  state_t     r_state;
  logic [6:0] r_sr;
  logic [2:0] r_cnt;
  logic [2:0] r_com_cnt;
  logic [7:0] r_out;
  logic       r_valid_out;
  logic       r_active;

  logic [7:0] w_window;
  logic       w_is_com;
  logic       w_boundary;
  logic [3:0] w_com_next;

  // Current byte candidate: the seven previous bits plus the bit on the line now
  assign w_window   = {r_sr, bus.in};
  assign w_is_com   = (w_window == COM);
  assign w_boundary = (r_cnt == 3'd7);
  assign w_com_next = {1'b0, r_com_cnt} + 4'd1;

  // Shift register, alignment state machine and registered outputs
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_UNALIGNED;
      r_sr        <= 7'd0;
      r_cnt       <= 3'd0;
      r_com_cnt   <= 3'd0;
      r_out       <= 8'h00;
      r_valid_out <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_sr        <= w_window[6:0];
      r_valid_out <= 1'b0;
      case (r_state)
        ST_UNALIGNED: begin
          // Bit-granular hunt; the counter restarts so the next byte begins now
          r_cnt <= 3'd0;
          if (w_is_com) begin
            r_com_cnt <= 3'd1;
            if (COM_NEEDED == 1) begin
              r_state  <= ST_ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= ST_ALIGNING;
            end
          end
        end
        ST_ALIGNING: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_boundary) begin
            if (w_is_com) begin
              if (w_com_next == c_com_needed) begin
                r_state  <= ST_ACTIVE;
                r_active <= 1'b1;
              end else begin
                r_com_cnt <= w_com_next[2:0];
              end
            end else begin
              // Candidate was false; fall back to the sliding search
              r_com_cnt <= 3'd0;
              r_state   <= ST_UNALIGNED;
            end
          end
        end
        ST_ACTIVE: begin
          // Locked until reset; COM bytes are idle fill and never delivered
          r_cnt <= r_cnt + 3'd1;
          if (w_boundary && !w_is_com) begin
            r_out       <= w_window;
            r_valid_out <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_UNALIGNED;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.valid_out = r_valid_out;
  assign bus.active    = r_active;

endmodule
`default_nettype wire
